// File: rtl/snake_dir_ctrl_pkg.sv
// Shared heading codes and screen geometry for the snake datapath.
// Also used by the draw FSM so both sides agree on the encoding.
package snake_dir_ctrl_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam int XSCREEN_D = 160;
  localparam int YSCREEN_D = 120;
  localparam int XDIM_D    = 10;
  localparam int YDIM_D    = 10;

  // The encoding makes every reverse heading the bitwise inverse.
  function automatic logic [1:0] dir_rev(
    input logic [1:0] d
  );
    return ~d;
  endfunction

endpackage

// File: rtl/snake_dir_ctrl_key_debounce.sv
// One pushbutton: 2-flop synchroniser, debounce counter, press pulse.
// Idle level is high; a press is a debounced high-to-low transition.
module key_debounce
  import snake_dir_ctrl_pkg::*;
#(
  parameter int DB_BITS = 20
) (
  input  logic CLOCK_50,
  input  logic Resetn,
  input  logic key,
  output logic press
);

  localparam logic [DB_BITS-1:0] CMAX = '1;

  logic              s1;
  logic              s2;
  logic              stable;
  logic [DB_BITS-1:0] cnt;

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      s1    <= key;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        stable <= s2;
        cnt    <= '0;
        press  <= stable & ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Key-driven heading buffer and edge-guarded move pulses for the snake.
// SNAKE_DIR_QUEUE_EN: 2-deep turn FIFO; otherwise one last-wins slot.
module snake_dir_ctrl
  import snake_dir_ctrl_pkg::*;
#(
  parameter int DB_BITS = 20,
  parameter int XSCREEN = XSCREEN_D,
  parameter int YSCREEN = YSCREEN_D,
  parameter int XDIM    = XDIM_D,
  parameter int YDIM    = YDIM_D
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [3:0] KEY,
  input  logic [7:0] X,
  input  logic [6:0] Y,
  input  logic       step,
  output logic       Ex,
  output logic       Ey,
  output logic       Xdir,
  output logic       Ydir,
  output logic [1:0] dir,
  output logic       moving,
  output logic       hit_wall
);

`ifdef SNAKE_DIR_QUEUE_EN
  localparam logic [1:0] QCAP = 2'd2;
`else
  localparam logic [1:0] QCAP = 2'd1;
`endif

  localparam logic [7:0] XMAX = 8'(XSCREEN - XDIM);
  localparam logic [6:0] YMAX = 7'(YSCREEN - YDIM);

  logic [3:0] press;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DB_BITS (DB_BITS)
    ) u_db (
      .CLOCK_50 (CLOCK_50),
      .Resetn   (Resetn),
      .key      (KEY[i]),
      .press    (press[i])
    );
  end

  logic       ev_v;
  logic [1:0] ev_d;

  always_comb begin
    ev_v = |press;
    ev_d = DIR_RIGHT;
    if (press[0])      ev_d = DIR_RIGHT;
    else if (press[1]) ev_d = DIR_DOWN;
    else if (press[2]) ev_d = DIR_UP;
    else if (press[3]) ev_d = DIR_LEFT;
  end

  logic [1:0] q0, q1, qcnt;
  logic [1:0] q0_n, q1_n, qcnt_n;
  logic [1:0] dir_n, ref_d;
  logic       moving_n, hit_n;
  logic       ex_n, ey_n;
  logic       xdir_n, ydir_n;

  always_comb begin
    q0_n     = q0;
    q1_n     = q1;
    qcnt_n   = qcnt;
    dir_n    = dir;
    moving_n = moving;
    hit_n    = hit_wall;
    ex_n     = 1'b0;
    ey_n     = 1'b0;
    xdir_n   = Xdir;
    ydir_n   = Ydir;
    ref_d    = dir;

    if (moving && step) begin
      if (qcnt != 2'd0) begin
        dir_n  = q0;
        q0_n   = q1;
        qcnt_n = qcnt - 2'd1;
      end
      // Heading still turns even if the wall blocks the move.
      unique case (dir_n)
        DIR_RIGHT: begin
          xdir_n = 1'b1;
          if (X == XMAX) hit_n = 1'b1;
          else           ex_n  = 1'b1;
        end
        DIR_LEFT: begin
          xdir_n = 1'b0;
          if (X == 8'd0) hit_n = 1'b1;
          else           ex_n  = 1'b1;
        end
        DIR_DOWN: begin
          ydir_n = 1'b1;
          if (Y == YMAX) hit_n = 1'b1;
          else           ey_n  = 1'b1;
        end
        DIR_UP: begin
          ydir_n = 1'b0;
          if (Y == 7'd0) hit_n = 1'b1;
          else           ey_n  = 1'b1;
        end
        default: ;
      endcase
    end

    if (ev_v) begin
      if (!moving) begin
        dir_n    = ev_d;
        moving_n = 1'b1;
      end else begin
        // Reference is the post-pop tail, so a step and a turn can coincide.
        case (qcnt_n)
          2'd0:    ref_d = dir_n;
          2'd1:    ref_d = q0_n;
          default: ref_d = q1_n;
        endcase
        if (ev_d != ref_d && ev_d != dir_rev(ref_d)) begin
          if (qcnt_n == 2'd0) begin
            q0_n   = ev_d;
            qcnt_n = 2'd1;
          end else if (qcnt_n < QCAP) begin
            q1_n   = ev_d;
            qcnt_n = 2'd2;
          end else if (QCAP == 2'd1) begin
            q0_n = ev_d;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      q0       <= DIR_RIGHT;
      q1       <= DIR_RIGHT;
      qcnt     <= 2'd0;
      dir      <= DIR_RIGHT;
      moving   <= 1'b0;
      hit_wall <= 1'b0;
      Ex       <= 1'b0;
      Ey       <= 1'b0;
      Xdir     <= 1'b1;
      Ydir     <= 1'b1;
    end else begin
      q0       <= q0_n;
      q1       <= q1_n;
      qcnt     <= qcnt_n;
      dir      <= dir_n;
      moving   <= moving_n;
      hit_wall <= hit_n;
      Ex       <= ex_n;
      Ey       <= ey_n;
      Xdir     <= xdir_n;
      Ydir     <= ydir_n;
    end
  end

endmodule
